// File: rtl/spi_byte_slave_if.sv
// ============================================================================
// spi_byte_slave_if : byte-level handshake between the SPI slave and the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface spi_byte_slave_if;
  logic       byte_received;
  logic [7:0] byte_data_received;
  logic [7:0] byte_send;
  logic       send_latch;
  logic       frame_active;

  modport slave (
    output byte_received,
    output byte_data_received,
    output frame_active,
    input  byte_send,
    input  send_latch
  );

  modport master (
    input  byte_received,
    input  byte_data_received,
    input  frame_active,
    output byte_send,
    output send_latch
  );
endinterface

`default_nettype wire

// File: rtl/spi_byte_slave.sv
// ============================================================================
// spi_byte_slave : SPI mode-0 byte slave, oversampled in the clock_50 domain
// Revision 1.0
// ============================================================================
`default_nettype none

module spi_byte_slave #(
  parameter int unsigned SYNC_DEPTH = 3,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  wire             clock_50,
  input  wire             reset,
  input  wire             SCK,
  input  wire             MOSI,
  input  wire             SSEL,
  output wire             MISO,
  spi_byte_slave_if.slave arb
);

  logic [SYNC_DEPTH-1:0] r_sck_sync;
  logic [SYNC_DEPTH-2:0] r_mosi_sync;
  logic [SYNC_DEPTH-1:0] r_ssel_sync;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_rx;
  logic [7:0]            r_tx;
  logic [7:0]            r_byte_data;
  logic                  r_byte_received;

  wire       w_active  = ~r_ssel_sync[SYNC_DEPTH-1];
  wire       w_rise    = ~r_sck_sync[SYNC_DEPTH-1] &  r_sck_sync[SYNC_DEPTH-2];
  wire       w_fall    =  r_sck_sync[SYNC_DEPTH-1] & ~r_sck_sync[SYNC_DEPTH-2];
  // MOSI chain is one stage shorter so its last tap aligns with SCK's newer compared tap
  wire       w_mosi    = r_mosi_sync[SYNC_DEPTH-2];
  wire [7:0] w_rx_next = {r_rx[6:0], w_mosi};

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_sck_sync      <= '0;
      r_mosi_sync     <= '0;
      r_ssel_sync     <= '1;
      r_bitcnt        <= 3'd0;
      r_rx            <= 8'h00;
      r_tx            <= FILL_BYTE;
      r_byte_data     <= 8'h00;
      r_byte_received <= 1'b0;
    end else begin
      r_sck_sync      <= {r_sck_sync[SYNC_DEPTH-2:0], SCK};
      r_mosi_sync     <= (r_mosi_sync << 1) | (SYNC_DEPTH-1)'(MOSI);
      r_ssel_sync     <= {r_ssel_sync[SYNC_DEPTH-2:0], SSEL};
      r_byte_received <= 1'b0;

      if (!w_active) begin
        // Idle or frame ended: any partial byte is discarded
        r_bitcnt <= 3'd0;
        r_rx     <= 8'h00;
      end else begin
        if (w_rise) begin
          r_rx     <= w_rx_next;
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            r_byte_received <= 1'b1;
            r_byte_data     <= w_rx_next;
          end
        end

        // Reload continuously at a byte boundary so late arbiter updates still land
        if (r_bitcnt == 3'd0) begin
          r_tx <= arb.send_latch ? arb.byte_send : FILL_BYTE;
        end else if (w_fall) begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign MISO                   = w_active ? r_tx[7] : 1'bz;
  assign arb.byte_received      = r_byte_received;
  assign arb.byte_data_received = r_byte_data;
  assign arb.frame_active       = w_active;

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_slave.sv
// ============================================================================
// tb_spi_byte_slave : randomized host-side SPI bench with a byte-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_spi_byte_slave;
  localparam int HALF = 6;  // clock_50 cycles per SCK phase (~4 MHz SCK)

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sck     = 1'b0;
  logic mosi    = 1'b0;
  logic ssel    = 1'b1;
  wire  miso;

  pullup pu_miso (miso);

  spi_byte_slave_if arb ();

  spi_byte_slave #(.SYNC_DEPTH(3), .FILL_BYTE(8'hFF)) dut (
    .clock_50 (clk),
    .reset    (reset_n),
    .SCK      (sck),
    .MOSI     (mosi),
    .SSEL     (ssel),
    .MISO     (miso),
    .arb      (arb.slave)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: records each received byte and the cycle it appeared in
  logic [7:0] got_q[$];
  int         got_t[$];
  int         cyc         = 0;
  int         long_pulses = 0;
  logic       prev_br     = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (arb.byte_received === 1'b1) begin
      if (prev_br) long_pulses++;
      else begin
        got_q.push_back(arb.byte_data_received);
        got_t.push_back(cyc);
      end
    end
    prev_br = (arb.byte_received === 1'b1);
  end

  logic       upd_en  = 1'b0;
  logic [7:0] upd_val = 8'h00;

  // Host clocks out n bits MSB first and reads MISO at each rising SCK edge
  task automatic shift_bits(input logic [7:0] b, input int n, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      sck   = 1'b1;
      rd[i] = miso;
      if (i == 0 && upd_en) begin
        repeat (4) @(negedge clk);
        arb.byte_send = upd_val;
        upd_en = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    ssel = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] b;
    checks++; if (arb.byte_received !== 1'b0) begin errors++; $display("FAIL reset_byte_received got=%b want=0", arb.byte_received); end
    checks++; if (arb.byte_data_received !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", arb.byte_data_received); end
    checks++; if (arb.frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got=%b want=0", arb.frame_active); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso_released got=%b want=1(pulled)", miso); end
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);

    b = 8'($urandom_range(1, 255));
    frame_start(); shift_bits(b, 8, rd); frame_end();
    checks++; if (arb.byte_data_received !== b) begin errors++; $display("FAIL pre_reset_byte got=%h want=%h", arb.byte_data_received, b); end

    // Reset in the middle of a byte while the frame is still selected
    frame_start(); shift_bits(8'($urandom), 5, rd);
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (arb.byte_data_received !== 8'h00) begin errors++; $display("FAIL midreset_data got=%h want=00", arb.byte_data_received); end
    checks++; if (arb.frame_active !== 1'b0) begin errors++; $display("FAIL midreset_frame_active got=%b want=0", arb.frame_active); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL midreset_miso_released got=%b want=1(pulled)", miso); end
    checks++; if (arb.byte_received !== 1'b0) begin errors++; $display("FAIL midreset_byte_received got=%b want=0", arb.byte_received); end
    ssel = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    got_q.delete(); got_t.delete();

    frame_start(); shift_bits(8'hA5, 8, rd); frame_end();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL post_reset_pulses got=%0d want=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL post_reset_data got=%h want=a5", got_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rd;
    logic [7:0] want_miso;
    int         n;
    for (int f = 0; f < 6; f++) begin
      got_q.delete(); got_t.delete(); exp_q.delete(); tx_q.delete();
      long_pulses = 0;
      arb.send_latch = 1'($urandom);
      arb.byte_send  = 8'($urandom);
      want_miso      = arb.send_latch ? arb.byte_send : 8'hFF;
      if (f == 0) begin
        tx_q.push_back(8'h01); tx_q.push_back(8'h12); tx_q.push_back(8'h34);
      end else begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      end
      frame_start();
      foreach (tx_q[k]) begin
        shift_bits(tx_q[k], 8, rd);
        exp_q.push_back(tx_q[k]);
        checks++; if (rd !== want_miso) begin errors++; $display("FAIL b2b_miso frame=%0d byte=%0d got=%h want=%h", f, k, rd, want_miso); end
      end
      frame_end();
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count frame=%0d got=%0d want=%0d", f, got_q.size(), exp_q.size()); end
      else begin
        foreach (exp_q[k]) begin
          checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_data frame=%0d byte=%0d got=%h want=%h", f, k, got_q[k], exp_q[k]); end
          if (k > 0) begin
            checks++; if (got_t[k] - got_t[k-1] < 16) begin errors++; $display("FAIL b2b_spacing frame=%0d got=%0d want>=16", f, got_t[k] - got_t[k-1]); end
          end
        end
      end
      checks++; if (long_pulses != 0) begin errors++; $display("FAIL b2b_pulse_width frame=%0d long=%0d want=0", f, long_pulses); end
    end
  endtask

  task automatic test_miso();
    logic [7:0] rd;
    logic [7:0] want;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin arb.send_latch = 1'b1; arb.byte_send = 8'h3C; end
        1: begin arb.send_latch = 1'b0; arb.byte_send = 8'($urandom); end
        default: begin arb.send_latch = 1'($urandom); arb.byte_send = 8'($urandom); end
      endcase
      want = arb.send_latch ? arb.byte_send : 8'hFF;
      frame_start(); shift_bits(8'($urandom), 8, rd); frame_end();
      checks++; if (rd !== want) begin errors++; $display("FAIL miso_byte case=%0d got=%h want=%h", c, rd, want); end
    end
  endtask

  task automatic test_late_update();
    logic [7:0] rd1;
    logic [7:0] rd2;
    arb.send_latch = 1'b1;
    arb.byte_send  = 8'h11;
    upd_val        = 8'h5A;
    frame_start();
    upd_en = 1'b1;
    shift_bits(8'($urandom), 8, rd1);
    shift_bits(8'($urandom), 8, rd2);
    frame_end();
    checks++; if (rd1 !== 8'h11) begin errors++; $display("FAIL late_update_first got=%h want=11", rd1); end
    checks++; if (rd2 !== 8'h5A) begin errors++; $display("FAIL late_update_second got=%h want=5a", rd2); end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    got_q.delete(); got_t.delete();
    frame_start(); shift_bits(8'($urandom), 4, rd);
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL abort_no_pulse got=%0d want=0", got_q.size()); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL abort_miso_released got=%b want=1(pulled)", miso); end
    checks++; if (arb.frame_active !== 1'b0) begin errors++; $display("FAIL abort_frame_active got=%b want=0", arb.frame_active); end
    frame_start(); shift_bits(8'h80, 8, rd); frame_end();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL abort_next_count got=%0d want=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h80) begin errors++; $display("FAIL abort_next_data got=%h want=80", got_q[0]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] rd;
    logic [7:0] prev;
    logic [7:0] b;
    prev = 8'($urandom);
    b    = 8'($urandom);
    got_q.delete(); got_t.delete();
    frame_start(); shift_bits(prev, 8, rd);
    shift_bits(b, 7, rd);
    mosi = b[0];
    repeat (HALF) @(negedge clk);
    // SSEL's final tap trails SCK's compared tap by one stage, so lead it by a clock
    ssel = 1'b1;
    @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL simul_pulses got=%0d want=1", got_q.size()); end
    checks++; if (arb.byte_data_received !== prev) begin errors++; $display("FAIL simul_data_held got=%h want=%h", arb.byte_data_received, prev); end
  endtask

  initial begin
    arb.byte_send  = 8'h00;
    arb.send_latch = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_miso();
    test_late_update();
    test_abort();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
